// File: rtl/proc_io_pkg.sv
// Shared types and constants for the floating-point processor I/O blocks.
// Both the input-side request blocks and the output collector import this package.
package proc_io_pkg;

    localparam int NUIOOU_DEF = 4;
    localparam int DWID_DEF   = 21;

    // Width of a port index for n ports. It is never narrower than one bit.
    function automatic int port_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PORT_W_DEF = (NUIOOU_DEF > 1) ? $clog2(NUIOOU_DEF) : 1;

    typedef struct packed {
        logic [PORT_W_DEF-1:0]      port;
        logic signed [DWID_DEF-1:0] data;
    } out_entry_t;

endpackage

// File: rtl/proc_out_collector_if.sv
// Consumer-side stream of the output collector: the head entry, shown ahead.
// Handshake: an entry transfers on a rising clk edge where m_valid && m_ready. m_valid never
// depends on m_ready. m_data and m_port hold steady while m_valid is high until that transfer.
interface proc_out_collector_if
    import proc_io_pkg::*;
#(
    parameter int DWID = DWID_DEF,
    parameter int PW   = PORT_W_DEF
) ();

    logic                   m_valid;
    logic                   m_ready;
    logic signed [DWID-1:0] m_data;
    logic [PW-1:0]          m_port;

    modport master (output m_valid, output m_data, output m_port, input m_ready);
    modport slave  (input m_valid, input m_data, input m_port, output m_ready);

endinterface

// File: rtl/proc_sync_fifo.sv
// Generic show-ahead FIFO built on a register array. The head word is kept in its own register.
// A push while full is accepted only when a pop happens in the same cycle.
module proc_sync_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = head_q;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        wr_d    = wr_q + AW'(do_push);
        level_d = level_q + LW'(do_push) - LW'(do_pop);
        // The new head is the incoming word when it lands exactly where the read pointer points next.
        if (do_push && (wr_q == rd_d)) begin
            head_d = wdata_i;
        end else if (do_pop) begin
            head_d = mem_q[rd_d];
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/proc_out_collector.sv
// Collects the processor's one-hot output-port writes into a FIFO of {port, data} entries.
// Defining OUT_COLLECTOR_DROPCNT_EN adds a saturating 16-bit counter of dropped pushes (drop_cnt).
module proc_out_collector
    import proc_io_pkg::*;
#(
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int DWID   = DWID_DEF,
    parameter int DEPTH  = 8,
    localparam int PW    = port_idx_w(NUIOOU),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [DWID-1:0] io_out,
    input  logic [NUIOOU-1:0]      out_en,
    proc_out_collector_if.master   m,
    output logic [LW-1:0]          level,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic                   sel_err
`ifdef OUT_COLLECTOR_DROPCNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    localparam int EW = PW + DWID;

    logic [PW-1:0] port_idx;
    logic          multi_sel;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          drop;
    logic [EW-1:0] head;
    logic          ovf_q, ovf_d;
    logic          sel_err_q, sel_err_d;

    // The lowest set strobe bit names the port, even when the strobe is not one-hot.
    always_comb begin
        port_idx = '0;
        for (int i = NUIOOU - 1; i >= 0; i--) begin
            if (out_en[i]) begin
                port_idx = PW'(i);
            end
        end
        multi_sel = |(out_en & (out_en - NUIOOU'(1)));
        push      = |out_en;
        pop       = m.m_valid && m.m_ready;
        drop      = push && full && !pop;
        ovf_d     = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        sel_err_d = sel_err_q || (push && multi_sel);
    end

    proc_sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({port_idx, io_out}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign m.m_valid = !empty;
    assign m.m_port  = head[EW-1 -: PW];
    assign m.m_data  = head[DWID-1:0];
    assign ovf       = ovf_q;
    assign sel_err   = sel_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q     <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            sel_err_q <= sel_err_d;
        end
    end

`ifdef OUT_COLLECTOR_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A clear that coincides with a drop still counts that drop.
    always_comb begin
        if (ovf_clr) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_proc_out_collector.sv
// Directed bench for proc_out_collector. Expected entries are hand-built and kept in a queue.
module tb_proc_out_collector;
  import proc_io_pkg::*;

  localparam int DW    = 21;
  localparam int NP    = 4;
  localparam int PW    = 2;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] io_out;
  logic [NP-1:0]        out_en;
  logic [LW-1:0]        level;
  logic                 ovf;
  logic                 ovf_clr;
  logic                 sel_err;
`ifdef OUT_COLLECTOR_DROPCNT_EN
  logic [15:0]          drop_cnt;
`endif

  proc_out_collector_if #(.DWID(DW), .PW(PW)) m_if ();

  proc_out_collector #(.NUIOOU(NP), .DWID(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_out  (io_out),
    .out_en  (out_en),
    .m       (m_if),
    .level   (level),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .sel_err (sel_err)
`ifdef OUT_COLLECTOR_DROPCNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [PW+DW-1:0] exp_q[$];
  logic [PW+DW-1:0] e;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [NP-1:0] en, input logic signed [DW-1:0] d);
    out_en = en;
    io_out = d;
    step();
    out_en = '0;
    io_out = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; out_en = '0; io_out = '0; ovf_clr = 1'b0; m_if.m_ready = 1'b0;
    step(); step();
    n_vec++; if (m_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", m_if.m_valid); end
    n_vec++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_vec++; if (ovf !== 1'b0 || sel_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got ovf=%0b sel_err=%0b exp 0 0", ovf, sel_err); end
    n_vec++; if (m_if.m_data !== 21'sd0 || m_if.m_port !== 2'd0) begin n_bad++; $display("FAIL reset_head got data=%0d port=%0d exp 0 0", m_if.m_data, m_if.m_port); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_dropcnt got=%0d exp=0", drop_cnt); end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    push_word(4'b0100, -21'sd5);
    n_vec++; if (m_if.m_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b exp=1", m_if.m_valid); end
    n_vec++; if (m_if.m_port !== 2'd2 || m_if.m_data !== -21'sd5) begin n_bad++; $display("FAIL single_head got port=%0d data=%0d exp port=2 data=-5", m_if.m_port, m_if.m_data); end
    n_vec++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level got=%0d exp=1", level); end
    m_if.m_ready = 1'b1;
    step();
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd0 || m_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop got level=%0d valid=%0b exp 0 0", level, m_if.m_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      push_word(NP'(1 << (i % 4)), DW'(i + 1));
      exp_q.push_back({PW'(i % 4), DW'(i + 1)});
    end
    n_vec++; if (level !== 4'd8 || ovf !== 1'b0) begin n_bad++; $display("FAIL fill_full got level=%0d ovf=%0b exp 8 0", level, ovf); end
    push_word(4'b0001, 21'sd9);
    n_vec++; if (level !== 4'd8 || ovf !== 1'b1) begin n_bad++; $display("FAIL fill_drop got level=%0d ovf=%0b exp 8 1", level, ovf); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL fill_dropcnt got=%0d exp=1", drop_cnt); end
`endif
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (m_if.m_valid !== 1'b1 || m_if.m_port !== e[DW +: PW] || m_if.m_data !== e[DW-1:0]) begin
        n_bad++;
        $display("FAIL fill_drain[%0d] got valid=%0b port=%0d data=%0d exp port=%0d data=%0d", i, m_if.m_valid, m_if.m_port, m_if.m_data, e[DW +: PW], $signed(e[DW-1:0]));
      end
      step();
    end
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd0 || m_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL fill_empty got level=%0d valid=%0b exp 0 0", level, m_if.m_valid); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_clr got=%0b exp=0", ovf); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 8; i++) begin
      push_word(NP'(1 << (i % 4)), DW'(i + 11));
      exp_q.push_back({PW'(i % 4), DW'(i + 11)});
    end
    n_vec++; if (m_if.m_data !== 21'sd11 || level !== 4'd8) begin n_bad++; $display("FAIL fpp_pre got data=%0d level=%0d exp 11 8", m_if.m_data, level); end
    m_if.m_ready = 1'b1;
    push_word(4'b0001, 21'sd100);
    m_if.m_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({2'd0, 21'd100});
    n_vec++; if (level !== 4'd8 || ovf !== 1'b0) begin n_bad++; $display("FAIL fpp_level got level=%0d ovf=%0b exp 8 0", level, ovf); end
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_vec++;
      if (m_if.m_valid !== 1'b1 || m_if.m_port !== e[DW +: PW] || m_if.m_data !== e[DW-1:0]) begin
        n_bad++;
        $display("FAIL fpp_drain[%0d] got valid=%0b port=%0d data=%0d exp port=%0d data=%0d", i, m_if.m_valid, m_if.m_port, m_if.m_data, e[DW +: PW], $signed(e[DW-1:0]));
      end
      step();
    end
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd0) begin n_bad++; $display("FAIL fpp_empty got level=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    m_if.m_ready = 1'b1;
    push_word(4'b0100, 21'sd55);
    n_vec++; if (level !== 4'd1 || m_if.m_data !== 21'sd55 || m_if.m_port !== 2'd2) begin n_bad++; $display("FAIL b2b_first got level=%0d data=%0d port=%0d exp 1 55 2", level, m_if.m_data, m_if.m_port); end
    push_word(4'b0010, 21'sd66);
    n_vec++; if (level !== 4'd1 || m_if.m_data !== 21'sd66 || m_if.m_port !== 2'd1) begin n_bad++; $display("FAIL b2b_second got level=%0d data=%0d port=%0d exp 1 66 1", level, m_if.m_data, m_if.m_port); end
    step();
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd0 || m_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty got level=%0d valid=%0b exp 0 0", level, m_if.m_valid); end
  endtask

  task automatic test_sel_err();
    push_word(4'b1010, 21'sd7);
    n_vec++; if (m_if.m_port !== 2'd1 || m_if.m_data !== 21'sd7) begin n_bad++; $display("FAIL sel_entry got port=%0d data=%0d exp 1 7", m_if.m_port, m_if.m_data); end
    n_vec++; if (sel_err !== 1'b1) begin n_bad++; $display("FAIL sel_set got=%0b exp=1", sel_err); end
    m_if.m_ready = 1'b1;
    step();
    m_if.m_ready = 1'b0;
    push_word(4'b0001, 21'sd8);
    n_vec++; if (sel_err !== 1'b1 || m_if.m_port !== 2'd0 || m_if.m_data !== 21'sd8) begin n_bad++; $display("FAIL sel_sticky got sel_err=%0b port=%0d data=%0d exp 1 0 8", sel_err, m_if.m_port, m_if.m_data); end
    m_if.m_ready = 1'b1;
    step();
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd0) begin n_bad++; $display("FAIL sel_empty got level=%0d exp=0", level); end
  endtask

  task automatic test_ovf_clr();
    for (int i = 0; i < 8; i++) begin
      push_word(4'b0001, DW'(i + 21));
      exp_q.push_back({2'd0, DW'(i + 21)});
    end
    n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL oc_pre got ovf=%0b exp=0", ovf); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL oc_pre_cnt got=%0d exp=0", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    push_word(4'b0001, 21'sd29);
    ovf_clr = 1'b0;
    n_vec++; if (ovf !== 1'b1 || level !== 4'd8) begin n_bad++; $display("FAIL oc_set_wins got ovf=%0b level=%0d exp 1 8", ovf, level); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL oc_cnt_one got=%0d exp=1", drop_cnt); end
`endif
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL oc_clear got ovf=%0b exp=0", ovf); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL oc_cnt_zero got=%0d exp=0", drop_cnt); end
`endif
    push_word(4'b0001, 21'sd30);
    push_word(4'b0010, 21'sd31);
    n_vec++; if (ovf !== 1'b1 || level !== 4'd8) begin n_bad++; $display("FAIL oc_redrop got ovf=%0b level=%0d exp 1 8", ovf, level); end
`ifdef OUT_COLLECTOR_DROPCNT_EN
    n_vec++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL oc_cnt_two got=%0d exp=2", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_vec++; if (m_if.m_data !== e[DW-1:0]) begin n_bad++; $display("FAIL rm_pop[%0d] got data=%0d exp=%0d", i, m_if.m_data, $signed(e[DW-1:0])); end
      step();
    end
    m_if.m_ready = 1'b0;
    n_vec++; if (level !== 4'd5 || m_if.m_valid !== 1'b1) begin n_bad++; $display("FAIL rm_level5 got level=%0d valid=%0b exp 5 1", level, m_if.m_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (m_if.m_valid !== 1'b0 || level !== 4'd0) begin n_bad++; $display("FAIL rm_async got valid=%0b level=%0d exp 0 0", m_if.m_valid, level); end
    n_vec++; if (ovf !== 1'b0 || sel_err !== 1'b0) begin n_bad++; $display("FAIL rm_flags got ovf=%0b sel_err=%0b exp 0 0", ovf, sel_err); end
    #1;
    rst = 1'b1;
    exp_q.delete();
    step();
    push_word(4'b1000, 21'sd42);
    n_vec++; if (m_if.m_data !== 21'sd42 || m_if.m_port !== 2'd3 || level !== 4'd1) begin n_bad++; $display("FAIL rm_after got data=%0d port=%0d level=%0d exp 42 3 1", m_if.m_data, m_if.m_port, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_back_to_back();
    test_sel_err();
    test_ovf_clr();
    test_reset_mid();
    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_out_collector.md
Name: proc_out_collector

Overview:
- Downstream of the floating-point processor wrapper.
- Captures each signed 21-bit integer result the processor writes to one of its output ports. A write is marked by a one-hot out_en strobe.
- Queues results as {port index, data} entries in a small FIFO and presents them to a consumer over a valid/ready handshake.
- Decouples the processor, which never stalls on output, from slower sinks. Dropped words are flagged.

Parameters:
- NUIOOU, 4, number of processor output ports (width of out_en).
- DWID, 21, width of the signed result word.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- io_out  in  DWID  signed result from the processor.
- out_en  in  NUIOOU  one-hot write strobe per output port.
- m_valid  out  1  head entry available.
- m_ready  in  1  consumer accepts the head entry.
- m_data  out  DWID  head entry data.
- m_port  out  clog2(NUIOOU)  head entry port index.
- level  out  clog2(DEPTH+1)  current occupancy.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- sel_err  out  1  sticky: more than one out_en bit was seen high in a cycle.

Behaviour:
- Reset: rst low clears asynchronously. Result: m_valid=0, level=0, ovf=0, sel_err=0, pointers=0; m_data and m_port read 0.
- Push request: any out_en bit high samples io_out on that clock edge.
  - Port index = lowest set bit of out_en.
  - If more than one bit is set, sel_err is set (sticky until reset) and the lowest index is still used.
- Pop: m_valid && m_ready at a clock edge.
- Head presentation: show-ahead. m_data/m_port always reflect the head entry, driven from registers.
- Latency: a push into an empty FIFO gives m_valid=1 in the cycle after the strobe edge, with the head already valid. No combinational path from out_en or io_out to any output.
- m_valid == (level != 0).
- Full, no pop: push is dropped, level unchanged, ovf set.
- Full with simultaneous pop: push accepted, level stays DEPTH, no overflow.
- Empty with simultaneous push: pop is impossible (m_valid=0); push accepted, level becomes 1.
- Push and pop in the same cycle, non-empty: level unchanged; head advances and the new entry is written at the tail.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. level disambiguates full from empty.
- ovf_clr: clears ovf on the next edge. If an overflow occurs in the same cycle, set wins and ovf stays 1.
- m_valid is held while m_ready is low; m_data/m_port are stable until popped.
- Reset mid-operation: all entries are discarded immediately, with no partial pop.

Optional Feature:
- OUT_COLLECTOR_DROPCNT_EN
  - Defined: adds output drop_cnt, 16 bits. It counts every dropped push, saturates at 16'hFFFF, and clears on reset or ovf_clr. If a drop and ovf_clr coincide, drop_cnt becomes 1.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package proc_io_pkg holds:
  - constants NUIOOU_DEF=4 and DWID_DEF=21;
  - a port-index width function (clog2);
  - typedef out_entry_t {port index, signed data}, shared with the input-side request blocks.
- One sub-module: proc_sync_fifo, a generic show-ahead register-array FIFO with push/pop/full/empty/level.
- proc_out_collector adds strobe encoding, error/overflow flags and the optional counter.

Test Plan:
- Reset, then single push: out_en=4'b0100, io_out=-5 → next cycle m_valid=1, m_port=2, m_data=-5, level=1. With m_ready=1 the FIFO pops; level=0, m_valid=0.
- Fill: 8 pushes with m_ready=0, values 1..8 on ports 0..3 cycling → level=8, ovf=0. A 9th push (value 9) → dropped, ovf=1, level=8. Drain → outputs 1..8 in order, ports 0,1,2,3,0,1,2,3.
- Full with simultaneous push (value 100) and pop → level stays 8, ovf stays 0, 100 is popped last after the remaining entries.
- Illegal strobe out_en=4'b1010, io_out=7 → entry m_port=1, m_data=7, sel_err=1 and stays 1 until reset.
- ovf_clr asserted in the same cycle as an overflowing push → ovf=1. ovf_clr alone on the next cycle → ovf=0. With OUT_COLLECTOR_DROPCNT_EN: drop_cnt reads 1 after the first cycle and 0 after the second.
- Reset asserted asynchronously mid-drain at level=5 → m_valid falls before the next clock edge, level=0. After release, pushing 42 on port 3 → head m_data=42, m_port=3.
